// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// PipeCtrl : pipeline sequencing controller for the five-stage F/D/E/M/W core.
//
// Combines the hazard unit's load-use request, fetch/data-memory busy
// signals, the multi-cycle MDU busy and execute-stage redirects into
// per-stage stall and bubble-insert (flush) controls plus a fetch PC
// override. A redirect that lands while a fetch is outstanding is parked in
// r_pendPc and the FSM enters DRAIN until the wrong-path fetch returns; that
// fetch is then squashed and the parked target is issued.
//
// Configuration macro: PIPE_CTRL_PERF_EN
//   defined   -> o_perf_stall counts cycles with o_stall_f asserted
//   undefined -> no counter register, o_perf_stall tied to 0
//
// Ports:
//   i_clk          core clock
//   i_reset        synchronous, active-low reset
//   i_loaduse      load-use stall request from the hazard unit
//   i_ibusy        fetch request outstanding (F holds no valid instruction)
//   i_dbusy        M-stage memory access outstanding
//   i_mdu_busy     E-stage multi-cycle op not yet complete
//   i_redirect     E-stage mispredict/jump
//   i_redirect_pc  redirect target
//   o_stall_f/d/e/m  hold the named stage's pipeline register
//   o_flush_d/e/m/w  load a bubble into the named stage at the next edge
//   o_pc_sel       fetch takes o_pc_next this cycle
//   o_pc_next      override PC (0 whenever o_pc_sel is 0)
//   o_drain        FSM is in DRAIN (debug)
//   o_perf_stall   stall-cycle counter (only live with PIPE_CTRL_PERF_EN)
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int PC_W  = 64,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_loaduse,
    input  logic             i_ibusy,
    input  logic             i_dbusy,
    input  logic             i_mdu_busy,
    input  logic             i_redirect,
    input  logic [PC_W-1:0]  i_redirect_pc,
    output logic             o_stall_f,
    output logic             o_stall_d,
    output logic             o_stall_e,
    output logic             o_stall_m,
    output logic             o_flush_d,
    output logic             o_flush_e,
    output logic             o_flush_m,
    output logic             o_flush_w,
    output logic             o_pc_sel,
    output logic [PC_W-1:0]  o_pc_next,
    output logic             o_drain,
    output logic [CNT_W-1:0] o_perf_stall
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pendPc;

    state_t          w_nextState;
    logic [PC_W-1:0] w_nextPendPc;

    // Priority-ordered control decode. Memory stalls dominate everything,
    // then the MDU, then redirects (E is advancing), then the DRAIN bookkeeping,
    // then load-use and fetch bubbles. While reset is low every stage is
    // bubbled and nothing stalls, so the pipe comes out of reset empty.
    always_comb begin
        o_stall_f    = 1'b0;
        o_stall_d    = 1'b0;
        o_stall_e    = 1'b0;
        o_stall_m    = 1'b0;
        o_flush_d    = 1'b0;
        o_flush_e    = 1'b0;
        o_flush_m    = 1'b0;
        o_flush_w    = 1'b0;
        o_pc_sel     = 1'b0;
        o_pc_next    = '0;
        w_nextState  = r_state;
        w_nextPendPc = r_pendPc;

        if (!i_reset) begin
            o_flush_d = 1'b1;
            o_flush_e = 1'b1;
            o_flush_m = 1'b1;
            o_flush_w = 1'b1;
        end else if (i_dbusy) begin
            o_stall_f = 1'b1;
            o_stall_d = 1'b1;
            o_stall_e = 1'b1;
            o_stall_m = 1'b1;
            o_flush_w = 1'b1;
        end else if (i_mdu_busy) begin
            o_stall_f = 1'b1;
            o_stall_d = 1'b1;
            o_stall_e = 1'b1;
            o_flush_m = 1'b1;
        end else if (i_redirect) begin
            // The D instruction is wrong-path, so load-use is irrelevant here.
            o_flush_d = 1'b1;
            o_flush_e = 1'b1;
            if (!i_ibusy && r_state == RUN) begin
                o_pc_sel  = 1'b1;
                o_pc_next = i_redirect_pc;
            end else begin
                // Park the target until the outstanding fetch drains; a newer
                // redirect simply overwrites an older parked one.
                o_stall_f    = 1'b1;
                w_nextPendPc = i_redirect_pc;
                w_nextState  = DRAIN;
            end
        end else if (r_state == DRAIN) begin
            o_flush_d = 1'b1;
            if (i_ibusy) begin
                o_stall_f = 1'b1;
            end else begin
                // Wrong-path fetch returns this cycle and is discarded by the
                // D flush while the parked target is issued.
                o_pc_sel    = 1'b1;
                o_pc_next   = r_pendPc;
                w_nextState = RUN;
            end
            if (i_loaduse) begin
                o_stall_d = 1'b1;
                o_flush_e = 1'b1;
            end
        end else if (i_loaduse) begin
            o_stall_f = 1'b1;
            o_stall_d = 1'b1;
            o_flush_e = 1'b1;
        end else if (i_ibusy) begin
            o_stall_f = 1'b1;
            o_flush_d = 1'b1;
        end
    end

    assign o_drain = i_reset && (r_state == DRAIN);

    // FSM state and parked redirect target. Reset drops any pending redirect.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state  <= RUN;
            r_pendPc <= '0;
        end else begin
            r_state  <= w_nextState;
            r_pendPc <= w_nextPendPc;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_perfStall;

    // Fetch-stall cycle counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_perfStall <= '0;
        end else if (o_stall_f) begin
            r_perfStall <= r_perfStall + 1'b1;
        end
    end

    assign o_perf_stall = r_perfStall;
`else
    assign o_perf_stall = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl : directed, table-driven bench for pipe_ctrl.
// Inputs are driven at the falling edge and outputs sampled 2 time units
// later, well before the next rising edge.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int PC_W  = 64;
    localparam int CNT_W = 32;

    logic             clk;
    logic             reset;
    logic             loaduse;
    logic             ibusy;
    logic             dbusy;
    logic             mduBusy;
    logic             redirect;
    logic [PC_W-1:0]  redirectPc;
    logic             stallF, stallD, stallE, stallM;
    logic             flushD, flushE, flushM, flushW;
    logic             pcSel;
    logic [PC_W-1:0]  pcNext;
    logic             drain;
    logic [CNT_W-1:0] perfStall;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic        lu;
        logic        ib;
        logic        db;
        logic        mb;
        logic        rd;
        logic [63:0] rpc;
        logic [3:0]  expStall;
        logic [3:0]  expFlush;
        logic        expSel;
        logic [63:0] expNext;
        logic        expDrain;
    } vec_t;

    vec_t vecs[$];

    pipe_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_loaduse     (loaduse),
        .i_ibusy       (ibusy),
        .i_dbusy       (dbusy),
        .i_mdu_busy    (mduBusy),
        .i_redirect    (redirect),
        .i_redirect_pc (redirectPc),
        .o_stall_f     (stallF),
        .o_stall_d     (stallD),
        .o_stall_e     (stallE),
        .o_stall_m     (stallM),
        .o_flush_d     (flushD),
        .o_flush_e     (flushE),
        .o_flush_m     (flushM),
        .o_flush_w     (flushW),
        .o_pc_sel      (pcSel),
        .o_pc_next     (pcNext),
        .o_drain       (drain),
        .o_perf_stall  (perfStall)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always terminates.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: timeout reached, required completion");
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t mk(input logic rst, input logic lu, input logic ib,
                                input logic db, input logic mb, input logic rd,
                                input logic [63:0] rpc, input logic [3:0] st,
                                input logic [3:0] fl, input logic sel,
                                input logic [63:0] nxt, input logic dr);
        vec_t v;
        v.rst = rst; v.lu = lu; v.ib = ib; v.db = db; v.mb = mb; v.rd = rd;
        v.rpc = rpc; v.expStall = st; v.expFlush = fl; v.expSel = sel;
        v.expNext = nxt; v.expDrain = dr;
        return v;
    endfunction

    // Drive one cycle's inputs at the falling edge, then settle.
    task automatic applyStimulus(input logic rst, input logic lu, input logic ib,
                                 input logic db, input logic mb, input logic rd,
                                 input logic [63:0] rpc);
        @(negedge clk);
        reset      = rst;
        loaduse    = lu;
        ibusy      = ib;
        dbusy      = db;
        mduBusy    = mb;
        redirect   = rd;
        redirectPc = rpc;
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    task automatic checkVector(input string tag, input vec_t v);
        checkOutput({tag, " stall"}, 64'({stallF, stallD, stallE, stallM}), 64'(v.expStall));
        checkOutput({tag, " flush"}, 64'({flushD, flushE, flushM, flushW}), 64'(v.expFlush));
        checkOutput({tag, " pc_sel"}, 64'(pcSel), 64'(v.expSel));
        checkOutput({tag, " pc_next"}, pcNext, v.expNext);
        checkOutput({tag, " drain"}, 64'(drain), 64'(v.expDrain));
    endtask

    initial begin
        reset = 1'b0; loaduse = 1'b0; ibusy = 1'b0; dbusy = 1'b0;
        mduBusy = 1'b0; redirect = 1'b0; redirectPc = '0;

        //            rst lu ib db mb rd  rpc            stall    flush    sel next           drain
        // Reset held with dbusy asserted
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 64'h0,          4'b0000, 4'b1111, 0, 64'h0,          0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 64'h0,          4'b0000, 4'b1111, 0, 64'h0,          0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 64'h0,          4'b0000, 4'b1111, 0, 64'h0,          0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 64'h0,          4'b0000, 4'b0000, 0, 64'h0,          0));
        // Load-use: one bubble
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 64'h0,          4'b1100, 4'b0100, 0, 64'h0,          0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 64'h0,          4'b0000, 4'b0000, 0, 64'h0,          0));
        // Redirect with fetch idle
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 64'h8000_0100,  4'b0000, 4'b1100, 1, 64'h8000_0100,  0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 64'h0,          4'b0000, 4'b0000, 0, 64'h0,          0));
        // Redirect during outstanding fetch, two more busy cycles, then return
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 64'h8000_0200,  4'b1000, 4'b1100, 0, 64'h0,          0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 64'h0,          4'b1000, 4'b1000, 0, 64'h0,          1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 64'h0,          4'b1000, 4'b1000, 0, 64'h0,          1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 64'h0,          4'b0000, 4'b1000, 1, 64'h8000_0200,  1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 64'h0,          4'b0000, 4'b0000, 0, 64'h0,          0));
        // Priority ladder
        vecs.push_back(mk(1, 1, 0, 1, 1, 1, 64'h8000_0300,  4'b1111, 4'b0001, 0, 64'h0,          0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 64'h8000_0300,  4'b1110, 4'b0010, 0, 64'h0,          0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 64'h8000_0300,  4'b0000, 4'b1100, 1, 64'h8000_0300,  0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 64'h0,          4'b1000, 4'b1000, 0, 64'h0,          0));
        // DRAIN persists through dbusy, honours loaduse, newest redirect wins
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 64'h8000_0400,  4'b1000, 4'b1100, 0, 64'h0,          0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 64'h0,          4'b1111, 4'b0001, 0, 64'h0,          1));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 64'h0,          4'b1100, 4'b1100, 0, 64'h0,          1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 64'h8000_0500,  4'b1000, 4'b1100, 0, 64'h0,          1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 64'h0,          4'b0000, 4'b1000, 1, 64'h8000_0500,  1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 64'h0,          4'b0000, 4'b0000, 0, 64'h0,          0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].lu, vecs[i].ib, vecs[i].db,
                          vecs[i].mb, vecs[i].rd, vecs[i].rpc);
            checkVector($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset while in DRAIN drops the parked redirect.
        applyStimulus(1, 0, 1, 0, 0, 1, 64'h8000_0600);
        applyStimulus(1, 0, 1, 0, 0, 0, 64'h0);
        checkOutput("drain before reset", 64'(drain), 64'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 64'h0);
        checkOutput("drain in reset", 64'(drain), 64'h0);
        checkOutput("flush in reset", 64'({flushD, flushE, flushM, flushW}), 64'hF);
        applyStimulus(1, 0, 0, 0, 0, 0, 64'h0);
        checkOutput("pc_sel after reset", 64'(pcSel), 64'h0);
        checkOutput("pc_next after reset", pcNext, 64'h0);
        checkOutput("flush_d after reset", 64'(flushD), 64'h0);

        // Stall-cycle counter: 5 load-use + 3 ibusy cycles.
        applyStimulus(0, 0, 0, 0, 0, 0, 64'h0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0, 0, 0, 64'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 0, 0, 64'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 64'h0);
`ifdef PIPE_CTRL_PERF_EN
        checkOutput("perf after 8 stalls", 64'(perfStall), 64'd8);
`else
        checkOutput("perf tied off", 64'(perfStall), 64'd0);
`endif
        applyStimulus(1, 1, 0, 0, 0, 0, 64'h0);
        applyStimulus(1, 1, 0, 0, 0, 0, 64'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 64'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 64'h0);
        checkOutput("perf after reset", 64'(perfStall), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage core (F/D/E/M/W). It merges the hazard unit's load-use request, the fetch and data-memory handshake busy signals, the multi-cycle MDU busy signal and execute-stage redirects. From these it produces per-stage stall and bubble-insert (flush) controls plus the fetch PC override. It holds a redirect that lands while an instruction fetch is outstanding, and discards the wrong-path fetch when it returns.

## Interface
Parameters:
- `PC_W`, 64, PC width.
- `CNT_W`, 32, perf counter width (used only with the configuration macro).

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-low reset.
- `loaduse`  in  1  load-use stall request from the hazard unit (D depends on a load in E).
- `ibusy`  in  1  fetch request outstanding; F has no valid instruction this cycle.
- `dbusy`  in  1  M-stage memory access outstanding.
- `mdu_busy`  in  1  E-stage multi-cycle op not yet complete.
- `redirect`  in  1  E-stage mispredict/jump. Held by E while E is stalled.
- `redirect_pc`  in  PC_W  redirect target.
- `stall_f`, `stall_d`, `stall_e`, `stall_m`  out  1 each  hold the named stage's pipeline register.
- `flush_d`, `flush_e`, `flush_m`, `flush_w`  out  1 each  load a bubble into the named stage's register at the next edge.
- `pc_sel`  out  1  fetch takes `pc_next` this cycle.
- `pc_next`  out  PC_W  override PC.
- `drain`  out  1  state == DRAIN (debug).
- `perf_stall`  out  CNT_W  stall-cycle count (macro only).

## Operation
- States: RUN, DRAIN. Registers: `state`, `pend_pc`.
- All outputs are combinational from the current inputs, `state` and `pend_pc`. Each cycle, the first matching rule below applies; every output not named is 0.
- Rule 1, `dbusy`:
  - stall_f, stall_d, stall_e, stall_m = 1; flush_w = 1.
  - Redirect and loaduse are ignored.
- Rule 2, `mdu_busy`:
  - stall_f, stall_d, stall_e = 1; flush_m = 1.
  - Redirect is ignored.
- Rule 3, `redirect` (E is advancing):
  - flush_d = 1, flush_e = 1. Loaduse is ignored because the D instruction is wrong-path.
  - If `ibusy`=0 and state=RUN: pc_sel = 1, pc_next = redirect_pc.
  - Otherwise (fetch outstanding, or a redirect arrives while in DRAIN): stall_f = 1, pend_pc ← redirect_pc, state ← DRAIN. The newest redirect wins.
- Rule 4, state=DRAIN:
  - flush_d = 1.
  - If `ibusy`=1: stall_f = 1.
  - If `ibusy`=0 (wrong-path fetch returns and is discarded): pc_sel = 1, pc_next = pend_pc, state ← RUN.
  - `loaduse` is still honoured in DRAIN: stall_d = 1 and flush_e = 1, in addition to the above.
- Rule 5, `loaduse`: stall_f, stall_d = 1; flush_e = 1.
- Rule 6, `ibusy`: stall_f = 1; flush_d = 1.
- Rule 7: all controls 0 (normal advance).
- `pc_next` = 0 whenever pc_sel = 0.
- DRAIN persists across dbusy/mdu_busy cycles; `pend_pc` holds.

## Timing
- State and `pend_pc` update on the rising edge of `clk`.
- Control outputs have zero-cycle latency: same cycle as the inputs.
- Redirect with no fetch outstanding: new PC fetched at the next edge.
- Redirect while a fetch is outstanding:
  - Redirect cycle: state → DRAIN.
  - N cycles of ibusy: held in DRAIN.
  - Cycle where ibusy=0: pc_sel asserted.
  - Exactly one wrong-path instruction is squashed.
- Load-use inserts exactly one bubble; the hazard unit deasserts `loaduse` the next cycle.
- Reset (reset=0 sampled at an edge):
  - state ← RUN, pend_pc ← 0, perf_stall ← 0.
  - While reset=0: all stall_* = 0, all flush_* = 1, pc_sel = 0, pc_next = 0, drain = 0.
  - A reset in DRAIN drops the pending redirect.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `perf_stall` increments by 1 on each edge with stall_f=1 and reset=1.
  - It wraps modulo 2^CNT_W and is cleared by reset.
- `PIPE_CTRL_PERF_EN` undefined: no counter register exists; `perf_stall` is tied to 0.

## Test plan
- Reset: hold reset=0 for 3 cycles with dbusy=1 → flush_d/e/m/w=1, all stalls 0; first cycle after reset=1 with idle inputs → all controls 0.
- Load-use: loaduse=1 for one cycle → stall_f=stall_d=1, flush_e=1, stall_e=0; next idle cycle → all 0.
- Redirect, fetch idle: redirect=1, redirect_pc=0x8000_0100 → pc_sel=1, pc_next=0x8000_0100, flush_d=flush_e=1, state stays RUN.
- Redirect during fetch:
  - Stimulus: redirect=1 (pc 0x8000_0200) with ibusy=1, then ibusy=1 for 2 more cycles, then ibusy=0.
  - Redirect cycle: drain goes 1 at the next edge; pc_sel=0 and stall_f=1.
  - Two DRAIN cycles with ibusy=1: pc_sel=0.
  - Cycle with ibusy=0: flush_d=1, pc_sel=1, pc_next=0x8000_0200; then state RUN.
- Priority: dbusy=1, mdu_busy=1, redirect=1, loaduse=1 together → stall_f/d/e/m=1, flush_w=1, pc_sel=0. Drop dbusy → stall_f/d/e=1, flush_m=1. Drop mdu_busy → redirect rule applies.
- Perf (macro on): 5 load-use cycles + 3 ibusy cycles → perf_stall=8. Reset mid-count → 0. With the macro off → perf_stall reads 0.
